// File: rtl/pulse_rate_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_rate_pkg                                                     |
// | Shared state encoding and default widths for pulse_rate_meter.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pulse_rate_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_WIN_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_rise_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_rise_detect                                                  |
// | One-cycle rising-edge strobe from a synchronous level input.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pulse_rise_detect (
    input  logic clk,
    input  logic async_rst,
    input  logic din,
    output logic rise
);

    logic r_pulse_d;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_pulse_d <= 1'b0;
        end else begin
            r_pulse_d <= din;
        end
    end

    assign rise = din & ~r_pulse_d;

endmodule
`default_nettype wire

// File: rtl/pulse_rate_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_rate_meter                                                   |
// | Counts rising edges of pulse_in over a programmable window.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pulse_rate_meter
    import pulse_rate_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             pulse_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow,
    output logic             count_valid,
    input  logic             count_ready
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] c_WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIN_W-1:0] r_win_left;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_rise;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ovf_next;

    pulse_rise_detect u_rise (
        .clk       (clk),
        .async_rst (async_rst),
        .din       (pulse_in),
        .rise      (w_rise)
    );

    // Saturating count: once at max, further edges only raise the sticky flag.
    always_comb begin
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        if (w_rise) begin
            if (r_count == c_CNT_MAX) begin
                w_ovf_next = 1'b1;
            end else begin
                w_count_next = r_count + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_state     <= IDLE;
            r_win_left  <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            busy        <= 1'b0;
            count_valid <= 1'b0;
            count_out   <= '0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= MEASURE;
                        busy       <= 1'b1;
                        r_win_left <= (window_len == '0) ? c_WIN_ONE : window_len;
                        r_count    <= '0;
                        r_ovf      <= 1'b0;
                    end
                end
                MEASURE: begin
                    r_count    <= w_count_next;
                    r_ovf      <= w_ovf_next;
                    r_win_left <= r_win_left - c_WIN_ONE;
                    // Last window cycle: its own edge is folded into the result.
                    if (r_win_left == c_WIN_ONE) begin
                        r_state     <= DONE;
                        busy        <= 1'b0;
                        count_valid <= 1'b1;
                        count_out   <= w_count_next;
                        overflow    <= w_ovf_next;
                    end
                end
                DONE: begin
                    if (count_ready) begin
                        r_state     <= IDLE;
                        count_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    busy        <= 1'b0;
                    count_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_rate_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pulse_rate_meter                                                |
// | Directed self-checking bench for pulse_rate_meter.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pulse_rate_meter;

    logic        clk = 1'b0;
    logic        async_rst;
    logic        pulse_in;
    logic        start;
    logic [23:0] window_len;
    logic        count_ready;

    logic        busy, count_valid, overflow;
    logic [15:0] count_out;
    logic        busy4, count_valid4, overflow4;
    logic [3:0]  count_out4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pulse_rate_meter dut (
        .clk         (clk),
        .async_rst   (async_rst),
        .pulse_in    (pulse_in),
        .start       (start),
        .window_len  (window_len),
        .busy        (busy),
        .count_out   (count_out),
        .overflow    (overflow),
        .count_valid (count_valid),
        .count_ready (count_ready)
    );

    pulse_rate_meter #(.CNT_W(4), .WIN_W(24)) dut4 (
        .clk         (clk),
        .async_rst   (async_rst),
        .pulse_in    (pulse_in),
        .start       (start),
        .window_len  (window_len),
        .busy        (busy4),
        .count_out   (count_out4),
        .overflow    (overflow4),
        .count_valid (count_valid4),
        .count_ready (count_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Current cycle is cycle 0 (start); returns positioned in cycle 'last'.
    task automatic drive_window(input logic [23:0] len, input logic [63:0] mask, input int last);
        window_len = len;
        start      = 1'b1;
        pulse_in   = mask[0];
        for (int k = 1; k <= last; k++) begin
            tick();
            start    = 1'b0;
            pulse_in = mask[k];
        end
    endtask

    task automatic handshake();
        count_ready = 1'b1;
        tick();
        count_ready = 1'b0;
        pulse_in    = 1'b0;
    endtask

    task automatic test_reset();
        async_rst = 1'b0; start = 1'b0; pulse_in = 1'b0; window_len = '0; count_ready = 1'b0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (count_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", count_valid); else n_pass++;
        n_checks++; if (count_out !== 16'd0) $display("FAIL reset_count: got %0d want 0", count_out); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
        async_rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [63:0] m;
        m = '0; m[1] = 1'b1; m[5] = 1'b1; m[10] = 1'b1;
        drive_window(24'd10, m, 10);
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_c10: got %b want 1", busy); else n_pass++;
        n_checks++; if (count_valid !== 1'b0) $display("FAIL basic_valid_c10: got %b want 0", count_valid); else n_pass++;
        tick(); pulse_in = 1'b0;
        n_checks++; if (count_valid !== 1'b1) $display("FAIL basic_valid_c11: got %b want 1", count_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_c11: got %b want 0", busy); else n_pass++;
        n_checks++; if (count_out !== 16'd3) $display("FAIL basic_count: got %0d want 3", count_out); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL basic_ovf: got %b want 0", overflow); else n_pass++;
        handshake();
        n_checks++; if (count_valid !== 1'b0) $display("FAIL basic_valid_after_xfer: got %b want 0", count_valid); else n_pass++;
    endtask

    task automatic test_long_pulse();
        logic [63:0] m;
        m = '0; m[9] = 1'b1;
        for (int k = 2; k <= 6; k++) m[k] = 1'b1;
        drive_window(24'd8, m, 9);
        n_checks++; if (count_valid !== 1'b1) $display("FAIL long_valid_c9: got %b want 1", count_valid); else n_pass++;
        n_checks++; if (count_out !== 16'd1) $display("FAIL long_count_c9: got %0d want 1", count_out); else n_pass++;
        tick(); pulse_in = 1'b0;
        n_checks++; if (count_out !== 16'd1) $display("FAIL long_count_c10: got %0d want 1", count_out); else n_pass++;
        handshake();
    endtask

    task automatic test_overflow();
        logic [63:0] m;
        m = '0;
        for (int k = 1; k <= 39; k += 2) m[k] = 1'b1;
        drive_window(24'd40, m, 40);
        tick(); pulse_in = 1'b0;
        n_checks++; if (count_valid4 !== 1'b1) $display("FAIL ovf_valid4: got %b want 1", count_valid4); else n_pass++;
        n_checks++; if (count_out4 !== 4'd15) $display("FAIL ovf_count4: got %0d want 15", count_out4); else n_pass++;
        n_checks++; if (overflow4 !== 1'b1) $display("FAIL ovf_flag4: got %b want 1", overflow4); else n_pass++;
        n_checks++; if (count_out !== 16'd20) $display("FAIL ovf_count16: got %0d want 20", count_out); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_flag16: got %b want 0", overflow); else n_pass++;
        handshake();
        m = '0; m[1] = 1'b1; m[3] = 1'b1;
        drive_window(24'd5, m, 5);
        tick(); pulse_in = 1'b0;
        n_checks++; if (count_out4 !== 4'd2) $display("FAIL ovf_next_count4: got %0d want 2", count_out4); else n_pass++;
        n_checks++; if (overflow4 !== 1'b0) $display("FAIL ovf_next_flag4: got %b want 0", overflow4); else n_pass++;
        handshake();
    endtask

    task automatic test_zero_len();
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy_c0: got %b want 0", busy); else n_pass++;
        drive_window(24'd0, 64'd0, 1);
        n_checks++; if (busy !== 1'b1) $display("FAIL zero_busy_c1: got %b want 1", busy); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy_c2: got %b want 0", busy); else n_pass++;
        n_checks++; if (count_valid !== 1'b1) $display("FAIL zero_valid_c2: got %b want 1", count_valid); else n_pass++;
        n_checks++; if (count_out !== 16'd0) $display("FAIL zero_count: got %0d want 0", count_out); else n_pass++;
        handshake();
    endtask

    task automatic test_back_pressure();
        logic [63:0] m;
        m = '0; m[2] = 1'b1;
        drive_window(24'd3, m, 4);
        pulse_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            count_ready = 1'b0;
            start = (i == 2);
            tick();
            start = 1'b0;
            n_checks++; if (count_valid !== 1'b1) $display("FAIL bp_valid_hold%0d: got %b want 1", i, count_valid); else n_pass++;
            n_checks++; if (count_out !== 16'd1) $display("FAIL bp_count_hold%0d: got %0d want 1", i, count_out); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy%0d: got %b want 0", i, busy); else n_pass++;
        end
        start = 1'b1; count_ready = 1'b1;
        tick();
        start = 1'b0; count_ready = 1'b0;
        n_checks++; if (count_valid !== 1'b0) $display("FAIL bp_valid_xfer: got %b want 0", count_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy_xfer: got %b want 0", busy); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_no_queue: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] m;
        m = '0; m[1] = 1'b1; m[3] = 1'b1;
        drive_window(24'd10, m, 4);
        #2 async_rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (count_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", count_valid); else n_pass++;
        n_checks++; if (count_out !== 16'd0) $display("FAIL rst_mid_count: got %0d want 0", count_out); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_mid_ovf: got %b want 0", overflow); else n_pass++;
        pulse_in = 1'b0;
        tick();
        async_rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pulse_in    = i[0];
            count_ready = (i > 6);
            tick();
            n_checks++; if (count_valid !== 1'b0) $display("FAIL rst_idle_valid%0d: got %b want 0", i, count_valid); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy%0d: got %b want 0", i, busy); else n_pass++;
        end
        count_ready = 1'b0;
        m = '0; m[1] = 1'b1;
        drive_window(24'd2, m, 2);
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_restart_busy: got %b want 1", busy); else n_pass++;
        tick(); pulse_in = 1'b0;
        n_checks++; if (count_valid !== 1'b1) $display("FAIL rst_restart_valid: got %b want 1", count_valid); else n_pass++;
        n_checks++; if (count_out !== 16'd1) $display("FAIL rst_restart_count: got %0d want 1", count_out); else n_pass++;
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_pulse();
        test_overflow();
        test_zero_len();
        test_back_pressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_rate_meter.md
PULSE_RATE_METER -- requirements
Module: pulse_rate_meter

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the event-count width in bits.
REQ-002 Parameter WIN_W, default 24, SHALL set the window-length width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 async_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pulse_in  input  1  SHALL be the synchronous event pulse from the upstream pulse detector's pulse_out, clk-domain.
REQ-006 start  input  1  SHALL request one measurement window; sampled only in IDLE.
REQ-007 window_len  input  WIN_W  SHALL give the window length in clk cycles; sampled with start.
REQ-008 busy  output  1  SHALL be high while in MEASURE.
REQ-009 count_out  output  CNT_W  SHALL carry the rising-edge count of the completed window.
REQ-010 overflow  output  1  SHALL flag that the count saturated in the completed window.
REQ-011 count_valid  output  1  SHALL qualify count_out/overflow.
REQ-012 count_ready  input  1  SHALL accept the result; transfer when count_valid and count_ready are both high.

Function
REQ-013 The block SHALL register pulse_in every cycle (pulse_d) and define edge = pulse_in & ~pulse_d, so a multi-cycle pulse counts once.
REQ-014 FSM SHALL have states IDLE, MEASURE, DONE; reset state IDLE.
REQ-015 IDLE -> MEASURE when start is high; the window counter SHALL load window_len, with 0 loaded as 1.
REQ-016 MEASURE SHALL last exactly N cycles (N = loaded length): if start is sampled at cycle 0, MEASURE covers cycles 1..N.
REQ-017 Each cycle in MEASURE with edge high SHALL increment the event count, including edges in cycle 1 and cycle N.
REQ-018 Edges outside MEASURE SHALL be ignored; pulse_d SHALL still update in every state.
REQ-019 At count value 2^CNT_W-1, further edges SHALL hold the count and set the overflow flag, which stays set until the next start.
REQ-020 After cycle N the FSM SHALL enter DONE; count_valid SHALL be high from cycle N+1, with count_out and overflow registered and stable.
REQ-021 In DONE, count_valid, count_out and overflow SHALL hold until the handshake; on transfer the FSM SHALL return to IDLE next cycle with count_valid low.
REQ-022 start SHALL be ignored in MEASURE and DONE, including start on the same cycle as the transfer; no request is queued.
REQ-023 count_ready while count_valid is low SHALL have no effect.
REQ-024 Entering MEASURE SHALL clear the event count and the overflow flag.

Reset
REQ-025 Asserting async_rst low SHALL immediately force IDLE, busy=0, count_valid=0, count_out=0, overflow=0, pulse_d=0 and clear the internal counters.
REQ-026 Reset mid-MEASURE or mid-DONE SHALL discard the partial or pending result; no count_valid follows deassertion.
REQ-027 After deassertion, the first start SHALL be honoured on the first clk edge where it is sampled high.

Structure
REQ-028 Package pulse_rate_pkg SHALL hold the state enum type (IDLE, MEASURE, DONE) and the default width constants for CNT_W and WIN_W.
REQ-029 The edge detect SHALL be sub-module pulse_rise_detect (clk, async_rst, din, rise); the FSM and counters SHALL stay in pulse_rate_meter.
REQ-030 The whole block SHALL be one clock domain with no combinational path from inputs to outputs.

Verification
REQ-031 window_len=10, start at cycle 0, three 1-cycle pulses at cycles 1, 5, 10 -> count_valid at cycle 11, count_out=3, overflow=0.
REQ-032 window_len=8, one pulse held high for cycles 2-6 -> count_out=1; a pulse at cycle 9 (outside the window) is not counted.
REQ-033 CNT_W=4, window_len=40, 20 pulses every other cycle -> count_out=15, overflow=1; the next window with 2 pulses -> count_out=2, overflow=0.
REQ-034 window_len=0 with start -> busy for exactly 1 cycle; count_valid at cycle 2 with count_out=0.
REQ-035 count_ready held low 5 cycles after count_valid -> outputs stable; start pulsed during DONE ignored; ready high -> IDLE next cycle.
REQ-036 async_rst low at cycle 4 of a 10-cycle window -> all outputs 0 at once; no count_valid afterwards until a new start.
